// File: rtl/popcount_seq_pkg.sv
// Shared types and width helpers for the iterative popcount engine.
// Also used by the bench to size its scoreboard.
package popcount_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(int dw, int cw);
    return dw / cw;
  endfunction

  function automatic int cnt_width(int dw);
    return $clog2(dw) + 1;
  endfunction

  function automatic int src_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/popcount_seq_if.sv
// Request/response bundle between requesters, consumer and the engine.
// master = requester/consumer side, slave = engine side.
interface popcount_seq_if
  import popcount_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2
);
  localparam int CntWidth = cnt_width(DATA_WIDTH);
  localparam int SrcWidth = src_width(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic                               rsp_valid_o;
  logic                               rsp_ready_i;
  logic [CntWidth-1:0]                rsp_count_o;
  logic [SrcWidth-1:0]                rsp_src_o;

  modport master (
    output req_valid_i,
    output req_data_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_count_o,
    input  rsp_src_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_count_o,
    output rsp_src_o
  );

endinterface

// File: rtl/popcount.sv
// Combinational population count of one INPUT_WIDTH-bit word.
// Output is wide enough to hold INPUT_WIDTH itself.
module popcount #(
  parameter int INPUT_WIDTH = 16
) (
  input  logic [INPUT_WIDTH-1:0]       data_i,
  output logic [$clog2(INPUT_WIDTH):0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      count_o = count_o + {{$clog2(INPUT_WIDTH){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/popcount_rr_arb.sv
// Round-robin one-hot grant: first valid requester at or after ptr_i.
// Reusable by other shared bit-manip units.
module popcount_rr_arb
  import popcount_seq_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  localparam int SrcWidth = src_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [SrcWidth-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && valid_i[j]) begin
        grant_o[j] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Shared iterative popcount: RR-arbitrated requesters, one chunk per
// cycle with early exit, tagged valid/ready response.
module popcount_seq
  import popcount_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 16,
  parameter int NUM_REQ     = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  output logic          busy_o,
  popcount_seq_if.slave bus
);

  localparam int NumChunks = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int CntWidth  = cnt_width(DATA_WIDTH);
  localparam int SrcWidth  = src_width(NUM_REQ);
  localparam int PcWidth   = $clog2(CHUNK_WIDTH) + 1;
  localparam int IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CntWidth-1:0]   acc_q, acc_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [SrcWidth-1:0]   src_q, src_d;
  logic [SrcWidth-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant;
  logic [SrcWidth-1:0]   gidx;
  logic [PcWidth-1:0]    chunk_cnt;

  popcount #(
    .INPUT_WIDTH(CHUNK_WIDTH)
  ) u_pc (
    .data_i (shreg_q[CHUNK_WIDTH-1:0]),
    .count_o(chunk_cnt)
  );

  popcount_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .valid_i(bus.req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = SrcWidth'(i);
    end
  end

  assign shifted = shreg_q >> CHUNK_WIDTH;

  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    acc_d           = acc_q;
    idx_d           = idx_q;
    src_d           = src_q;
    ptr_d           = ptr_q;
    bus.req_ready_o = '0;
    if (flush_i) begin
      // Flush wins over accept and handshake alike.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          bus.req_ready_o = grant;
          if (|grant) begin
            shreg_d = bus.req_data_i[gidx];
            acc_d   = '0;
            idx_d   = '0;
            src_d   = gidx;
            ptr_d   = SrcWidth'((int'(gidx) + 1) % NUM_REQ);
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d   = acc_q + CntWidth'(chunk_cnt);
          shreg_d = shifted;
          idx_d   = idx_q + IdxWidth'(1);
          if (idx_q == IdxWidth'(NumChunks - 1) || shifted == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.rsp_valid_o = (state_q == DONE);
  assign bus.rsp_count_o = acc_q;
  assign bus.rsp_src_o   = src_q;
  assign busy_o          = (state_q != IDLE);

endmodule
